instruction_encoder: RTL and testbench

- Packs decoded MIPS instruction fields back into 32-bit instruction words. It is the inverse of the instruction decoder.
- Used by the keyboard-input simulation path to assemble instructions at run time and stream them to instruction-memory write logic.
- Input and output sides each use a valid/ready handshake, with a small FIFO between them.
- Each emitted word is tagged with a sequential instruction-memory word address.

---
 rtl/instruction_encoder.sv | 109 ++++++++++
 tb/tb_instruction_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Packs decoded MIPS instruction fields into 32-bit words and queues them,
// each tagged with a sequential instruction-memory word address, in a small
// FIFO with valid/ready handshakes on both sides.
module instruction_encoder #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [5:0]                opcode,
    input  logic [4:0]                rs,
    input  logic [4:0]                rt,
    input  logic [4:0]                rd,
    input  logic [4:0]                shamt,
    input  logic [5:0]                funct,
    input  logic [15:0]               immediate,
    input  logic [25:0]               address,
    input  logic                      addr_clear,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               instruction,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    logic [31:0]           enc_word;
    logic                  ready_sync_reg;
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [ADDR_WIDTH-1:0] addr_cnt_reg;
    logic [ADDR_WIDTH-1:0] entry_tag;
    logic                  push;
    logic                  pop;

    logic [31:0]           word_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] tag_mem  [DEPTH];

    // Select the instruction format from the opcode; unused fields drop out.
    always_comb begin
        enc_word = {opcode, rs, rt, immediate};
        case (opcode)
            6'b000000:            enc_word = {opcode, rs, rt, rd, shamt, funct};
            6'b000010, 6'b000011: enc_word = {opcode, address};
            default: ;
        endcase
    end

    // A same-cycle addr_clear takes effect for the word being accepted.
    assign entry_tag = addr_clear ? BASE : addr_cnt_reg;

    assign in_ready  = ready_sync_reg && (count_reg < CNT_W'(DEPTH)) && !flush;
    assign push      = in_valid && in_ready;
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_reg;

    // Head outputs are forced to zero whenever the FIFO is empty.
    assign instruction = out_valid ? word_mem[rd_ptr_reg] : 32'd0;
    assign mem_addr    = out_valid ? tag_mem[rd_ptr_reg]  : '0;

    // Releases in_ready one clock edge after reset deasserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_sync_reg <= 1'b0;
        else        ready_sync_reg <= 1'b1;
    end

    // Storage array: write the encoded word and its tag at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr_reg] <= enc_word;
            tag_mem[wr_ptr_reg]  <= entry_tag;
        end
    end

    // FIFO pointers and occupancy; flush empties the queue and wins over pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (!push && pop) count_reg <= count_reg - 1'b1;
        end
    end

    // Address counter: advances per accepted word, reloadable by addr_clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          addr_cnt_reg <= BASE;
        else if (push)       addr_cnt_reg <= entry_tag + 1'b1;
        else if (addr_clear) addr_cnt_reg <= BASE;
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench: hand-computed vectors, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_instruction_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int BASE  = 0;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] adr;
    } fields_t;

    typedef struct {
        fields_t     f;
        logic        clr;
        logic [31:0] exp_word;
        logic [AW-1:0] exp_tag;
    } vec_t;

    typedef struct {
        logic [31:0]   w;
        logic [AW-1:0] t;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [5:0]    opcode, funct;
    logic [4:0]    rs, rt, rd, shamt;
    logic [15:0]   immediate;
    logic [25:0]   address;
    logic          addr_clear, flush;
    logic          out_valid, out_ready;
    logic [31:0]   instruction;
    logic [AW-1:0] mem_addr;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    ent_t          q[$];
    logic [AW-1:0] cnt;
    bit            synced;

    instruction_encoder #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .immediate(immediate), .address(address), .addr_clear(addr_clear),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .instruction(instruction), .mem_addr(mem_addr), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic fields_t mk(input int op, input int rs_v, input int rt_v, input int rd_v,
                                   input int sh_v, input int fn_v, input int imm_v, input int adr_v);
        fields_t f;
        f.op = 6'(op); f.rs = 5'(rs_v); f.rt = 5'(rt_v); f.rd = 5'(rd_v);
        f.sh = 5'(sh_v); f.fn = 6'(fn_v); f.imm = 16'(imm_v); f.adr = 26'(adr_v);
        return f;
    endfunction

    function automatic fields_t rnd_fields();
        fields_t f;
        int sel = $urandom_range(0, 3);
        f = mk($urandom_range(0, 63), $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom);
        if (sel == 0) f.op = 6'd0;
        else if (sel == 1) f.op = 6'($urandom_range(2, 3));
        return f;
    endfunction

    // Encoding from the MIPS format rules using positional arithmetic.
    function automatic logic [31:0] model_enc(input fields_t f);
        longint unsigned w;
        longint unsigned op = f.op;
        if (f.op == 0)
            w = op * 64'd67108864 + f.rs * 64'd2097152 + f.rt * 64'd65536
              + f.rd * 64'd2048 + f.sh * 64'd64 + f.fn;
        else if (f.op == 2 || f.op == 3)
            w = op * 64'd67108864 + f.adr;
        else
            w = op * 64'd67108864 + f.rs * 64'd2097152 + f.rt * 64'd65536 + f.imm;
        return w[31:0];
    endfunction

    // One clock of stimulus, entered and left at a falling edge.
    task automatic cycle(input logic iv, input logic ordy, input logic fl,
                         input logic clr, input fields_t f);
        bit exp_rdy, acc, pp;
        ent_t e;
        logic [AW-1:0] tag;
        in_valid = iv; out_ready = ordy; flush = fl; addr_clear = clr;
        opcode = f.op; rs = f.rs; rt = f.rt; rd = f.rd; shamt = f.sh;
        funct = f.fn; immediate = f.imm; address = f.adr;
        #1;
        exp_rdy = synced && (q.size() < DEPTH) && !fl;
        chk("in_ready", in_ready, exp_rdy);
        acc = iv && exp_rdy;
        pp  = (q.size() != 0) && ordy && !fl;
        if (fl) q.delete();
        else if (pp) begin
            e = q.pop_front();
            $display("pop word=%08h tag=%0d", e.w, e.t);
        end
        if (acc) begin
            tag = clr ? AW'(BASE) : cnt;
            e.w = model_enc(f); e.t = tag;
            q.push_back(e);
            cnt = tag + 1'b1;
        end else if (clr) cnt = AW'(BASE);
        @(negedge clk);
        synced = 1;
        chk("out_valid", out_valid, q.size() != 0);
        chk("count", count, q.size());
        chk("instruction", instruction, (q.size() != 0) ? q[0].w : 32'd0);
        chk("mem_addr", mem_addr, (q.size() != 0) ? q[0].t : '0);
    endtask

    task automatic drain();
        fields_t z = mk(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) cycle(0, 1, 0, 0, z);
        chk("drained", count, 0);
    endtask

    vec_t vecs[6];

    initial begin
        fields_t z;
        logic [AW-1:0] saved;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0);

        vecs[0].f = mk(6'h00, 1, 2, 3, 0, 6'h20, 16'hBEEF, 26'h155AAAA);
        vecs[0].clr = 0; vecs[0].exp_word = 32'h00221820; vecs[0].exp_tag = 0;
        vecs[1].f = mk(6'h23, 29, 8, 31, 31, 6'h3F, 16'hFFFC, 26'h3FFFFFF);
        vecs[1].clr = 1; vecs[1].exp_word = 32'h8FA8FFFC; vecs[1].exp_tag = 0;
        vecs[2].f = mk(6'h08, 0, 8, 21, 17, 6'h2A, 16'h0005, 26'h2AAAAAA);
        vecs[2].clr = 0; vecs[2].exp_word = 32'h20080005; vecs[2].exp_tag = 1;
        vecs[3].f = mk(6'h02, 31, 31, 7, 9, 6'h11, 16'hFFFF, 26'h0100000);
        vecs[3].clr = 0; vecs[3].exp_word = 32'h08100000; vecs[3].exp_tag = 2;
        vecs[4].f = mk(6'h03, 21, 10, 5, 3, 6'h01, 16'h1234, 26'h3FFFFFF);
        vecs[4].clr = 0; vecs[4].exp_word = 32'h0FFFFFFF; vecs[4].exp_tag = 3;
        vecs[5].f = mk(6'h00, 0, 9, 8, 4, 6'h00, 16'hAAAA, 26'h0);
        vecs[5].clr = 0; vecs[5].exp_word = 32'h00094100; vecs[5].exp_tag = 0;

        // Reset state
        rst_n = 0; in_valid = 0; out_ready = 0; flush = 0; addr_clear = 0;
        opcode = 0; rs = 0; rt = 0; rd = 0; shamt = 0; funct = 0;
        immediate = 0; address = 0;
        cnt = AW'(BASE); synced = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_instruction", instruction, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        // First edge after release: offered word must be refused
        cycle(1, 0, 0, 0, vecs[0].f);

        // Table-driven vectors, each pushed into an empty FIFO then popped
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 0, vecs[i].clr, vecs[i].f);
            chk("vec_valid", out_valid, 1);
            chk("vec_word", instruction, vecs[i].exp_word);
            chk("vec_tag", mem_addr, vecs[i].exp_tag);
            cycle(0, 1, 0, 0, z);
        end

        // Backpressure: five offers into a stalled FIFO, then release
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, rnd_fields());
        chk("full_count", count, DEPTH);
        chk("full_in_ready", in_ready, 0);
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, rnd_fields());
        drain();

        // flush with pop and offer pending; counter must continue
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, rnd_fields());
        saved = cnt;
        cycle(1, 1, 1, 0, rnd_fields());
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        cycle(1, 0, 0, 0, rnd_fields());
        chk("flush_tag", mem_addr, saved);
        drain();

        // Asynchronous reset between edges
        cycle(1, 0, 0, 0, rnd_fields());
        cycle(1, 0, 0, 0, rnd_fields());
        #2 rst_n = 0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_instruction", instruction, 0);
        chk("arst_count", count, 0);
        chk("arst_in_ready", in_ready, 0);
        q.delete(); cnt = AW'(BASE); synced = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0, rnd_fields());
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
